// File: rtl/step_clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_clock_pkg : shared types and constants for step_clock_gen        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package step_clock_pkg;

   typedef enum logic {
      MODE_TICK   = 1'b0,
      MODE_SQUARE = 1'b1
   } mode_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   localparam int DIV_MIN     = 2;
   localparam int CNT_W_DEF   = 21;
   localparam int DIV_RST_DEF = 8000;

endpackage
`default_nettype wire

// File: rtl/step_clock_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_clock_ch : one divider channel with shadowed div/mode update     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module step_clock_ch
   import step_clock_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_div,
   input  mode_e            cfg_mode,
   output logic             pending,
   output logic             cp,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] C_DIV_RST = CNT_W'(DIV_RST);
   localparam logic [CNT_W-1:0] C_DIV_MIN = CNT_W'(DIV_MIN);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   ch_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_div, w_div_nxt;
   logic [CNT_W-1:0] r_sh_div, w_sh_div_nxt;
   mode_e            r_mode, w_mode_nxt;
   mode_e            r_sh_mode, w_sh_mode_nxt;
   logic             r_pend, w_pend_nxt;
   logic             r_cp, w_cp_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             w_apply;
   logic [CNT_W-1:0] w_deff;
   logic [CNT_W-1:0] w_last;

   // Small divisors are kept as written but counted as the minimum period.
   assign w_deff = (r_div < C_DIV_MIN) ? C_DIV_MIN : r_div;
   assign w_last = w_deff - C_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_div     <= C_DIV_RST;
         r_mode    <= MODE_TICK;
         r_sh_div  <= C_DIV_RST;
         r_sh_mode <= MODE_TICK;
         r_pend    <= 1'b0;
         r_cp      <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_div     <= w_div_nxt;
         r_mode    <= w_mode_nxt;
         r_sh_div  <= w_sh_div_nxt;
         r_sh_mode <= w_sh_mode_nxt;
         r_pend    <= w_pend_nxt;
         r_cp      <= w_cp_nxt;
         r_wrap    <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_div_nxt     = r_div;
      w_mode_nxt    = r_mode;
      w_sh_div_nxt  = r_sh_div;
      w_sh_mode_nxt = r_sh_mode;
      w_pend_nxt    = r_pend;
      w_cp_nxt      = 1'b0;
      w_wrap_nxt    = 1'b0;
      w_apply       = 1'b0;

      // cfg_we only fires while pending is clear, so it never races an apply.
      if (cfg_we) begin
         w_sh_div_nxt  = cfg_div;
         w_sh_mode_nxt = cfg_mode;
         w_pend_nxt    = 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            w_apply   = r_pend;
            if (en) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (sync) begin
               w_cnt_nxt = '0;
               w_apply   = r_pend;
            end else if (r_cnt >= w_last) begin
               w_cnt_nxt  = '0;
               w_wrap_nxt = 1'b1;
               w_cp_nxt   = (r_mode == MODE_TICK);
               w_apply    = r_pend;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
               w_cp_nxt  = (r_mode == MODE_SQUARE) && (r_cnt < (w_deff >> 1));
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_apply) begin
         w_div_nxt  = r_sh_div;
         w_mode_nxt = r_sh_mode;
         w_pend_nxt = 1'b0;
      end
   end

   assign pending = r_pend;
   assign cp      = r_cp;
   assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: rtl/step_clock_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_clock_gen : multi-channel programmable clock/tick divider        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module step_clock_gen
   import step_clock_pkg::*;
#(
   parameter int  NUM_CH  = 2,
   parameter int  CNT_W   = CNT_W_DEF,
   parameter int  DIV_RST = DIV_RST_DEF,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   output logic [NUM_CH-1:0] cp,
   output logic [NUM_CH-1:0] wrap
);

   logic [NUM_CH-1:0]      w_pending;
   logic [NUM_CH-1:0]      w_cfg_we;
   logic [(2**CH_W)-1:0]   w_pend_ext;
   logic                   w_xfer;
   mode_e                  w_cfg_mode;

   // Unpopulated channel codes read as busy so they are never accepted.
   for (genvar g = 0; g < 2**CH_W; g++) begin : g_pend_ext
      if (g < NUM_CH) begin : g_real
         assign w_pend_ext[g] = w_pending[g];
      end else begin : g_pad
         assign w_pend_ext[g] = 1'b1;
      end
   end

   assign cfg_ready  = ~w_pend_ext[cfg_ch];
   assign w_xfer     = cfg_valid & cfg_ready;
   assign w_cfg_mode = mode_e'(cfg_mode);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_cfg_we[g] = w_xfer && (cfg_ch == CH_W'(g));

      step_clock_ch #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[g]),
         .sync     (sync),
         .cfg_we   (w_cfg_we[g]),
         .cfg_div  (cfg_div),
         .cfg_mode (w_cfg_mode),
         .pending  (w_pending[g]),
         .cp       (cp[g]),
         .wrap     (wrap[g])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_step_clock_gen.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_step_clock_gen : randomized and directed bench for step_clock_gen  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_step_clock_gen;

   localparam int NCH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  en = '0;
   logic        sync = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [0:0]  cfg_ch = '0;
   logic [20:0] cfg_div = '0;
   logic        cfg_mode = 1'b0;
   logic [1:0]  cp;
   logic [1:0]  wrap;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: each running channel remembers the edge its period began.
   int m_run[NCH], m_start[NCH], m_div[NCH], m_mode[NCH];
   int m_sdiv[NCH], m_smode[NCH], m_pend[NCH];
   logic [1:0] m_cp, m_wrap;
   int e = 0;

   step_clock_gen #(.NUM_CH(2), .CNT_W(21), .DIV_RST(8000)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cp(cp), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_start[c] = 0; m_div[c] = 8000; m_mode[c] = 0;
         m_sdiv[c] = 8000; m_smode[c] = 0; m_pend[c] = 0;
      end
      m_cp = '0; m_wrap = '0;
   endtask

   task automatic tick();
      bit acc;
      @(posedge clk);
      e++;
      acc = cfg_valid && (m_pend[cfg_ch] == 0);
      for (int c = 0; c < NCH; c++) begin
         bit apply;
         int eff, k;
         apply = 0; m_cp[c] = 1'b0; m_wrap[c] = 1'b0;
         eff = (m_div[c] < 2) ? 2 : m_div[c];
         if (m_run[c] == 0) begin
            apply = (m_pend[c] != 0);
            if (en[c]) begin m_run[c] = 1; m_start[c] = e; end
         end else if (!en[c]) begin
            m_run[c] = 0;
         end else if (sync) begin
            m_start[c] = e; apply = (m_pend[c] != 0);
         end else begin
            k = e - m_start[c];
            if (k >= eff) begin
               m_wrap[c] = 1'b1; m_cp[c] = (m_mode[c] == 0);
               m_start[c] = e; apply = (m_pend[c] != 0);
            end else begin
               m_cp[c] = (m_mode[c] == 1) && (k <= eff / 2);
            end
         end
         if (apply) begin m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 0; end
         if (acc && cfg_ch == c) begin
            m_sdiv[c] = cfg_div; m_smode[c] = cfg_mode; m_pend[c] = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (cp !== 2'b00) $display("FAIL reset_cp got %b want 00", cp); else n_pass++;
      n_total++; if (wrap !== 2'b00) $display("FAIL reset_wrap got %b want 00", wrap); else n_pass++;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready ch0 got %b want 1", cfg_ready); else n_pass++;
      repeat (2) @(posedge clk);
      cfg_ch = 1'b1; #1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready ch1 got %b want 1", cfg_ready); else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      tick();
      n_total++; if ({cp, wrap} !== 4'b0000) $display("FAIL post_reset got %b want 0000", {cp, wrap}); else n_pass++;
   endtask

   task automatic test_default_period();
      int e_en, first, prev, gap, npulse;
      en[0] = 1'b1; e_en = e + 1;
      first = -1; prev = 0; gap = 0; npulse = 0;
      for (int i = 0; i < 16005; i++) begin
         tick();
         n_total++; if (cp !== m_cp) $display("FAIL default_cp e=%0d got %b want %b", e, cp, m_cp); else n_pass++;
         n_total++; if (wrap !== m_wrap) $display("FAIL default_wrap e=%0d got %b want %b", e, wrap, m_wrap); else n_pass++;
         if (cp[0] === 1'b1) begin
            if (npulse == 0) first = e; else gap = e - prev;
            prev = e; npulse++;
         end
      end
      n_total++; if (npulse != 2) $display("FAIL default_npulse got %0d want 2", npulse); else n_pass++;
      n_total++; if (first - e_en != 8000) $display("FAIL default_first got %0d want 8000", first - e_en); else n_pass++;
      n_total++; if (gap != 8000) $display("FAIL default_gap got %0d want 8000", gap); else n_pass++;
      en[0] = 1'b0; tick();
   endtask

   task automatic test_square7();
      logic exp_cp, exp_wrap;
      cfg_ch = 1'b1; cfg_div = 21'd7; cfg_mode = 1'b1; cfg_valid = 1'b1; #1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL sq7_ready_pre got %b want 1", cfg_ready); else n_pass++;
      tick(); cfg_valid = 1'b0; #1;
      n_total++; if (cfg_ready !== 1'b0) $display("FAIL sq7_ready_pend got %b want 0", cfg_ready); else n_pass++;
      tick();
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL sq7_ready_apply got %b want 1", cfg_ready); else n_pass++;
      en[1] = 1'b1;
      for (int i = 0; i <= 28; i++) begin
         tick();
         n_total++; if (cp !== m_cp) $display("FAIL sq7_cp e=%0d got %b want %b", e, cp, m_cp); else n_pass++;
         n_total++; if (wrap !== m_wrap) $display("FAIL sq7_wrap e=%0d got %b want %b", e, wrap, m_wrap); else n_pass++;
         if (i >= 1) begin
            exp_cp = ((i - 1) % 7) < 3;
            exp_wrap = (i % 7) == 0;
            n_total++; if (cp[1] !== exp_cp) $display("FAIL sq7_pattern_cp i=%0d got %b want %b", i, cp[1], exp_cp); else n_pass++;
            n_total++; if (wrap[1] !== exp_wrap) $display("FAIL sq7_pattern_wrap i=%0d got %b want %b", i, wrap[1], exp_wrap); else n_pass++;
         end
      end
      en[1] = 1'b0; tick();
   endtask

   task automatic test_cfg_boundary();
      int e_en, nw;
      int w[3];
      cfg_ch = 1'b0; cfg_div = 21'd10; cfg_mode = 1'b0; cfg_valid = 1'b1;
      tick(); cfg_valid = 1'b0; tick();
      en[0] = 1'b1; e_en = e + 1;
      repeat (4) tick();
      cfg_div = 21'd4; cfg_valid = 1'b1; #1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL bnd_ready_pre got %b want 1", cfg_ready); else n_pass++;
      tick();
      cfg_div = 21'd6;
      repeat (3) begin
         #1;
         n_total++; if (cfg_ready !== 1'b0) $display("FAIL bnd_holdoff e=%0d got %b want 0", e, cfg_ready); else n_pass++;
         tick();
      end
      cfg_valid = 1'b0;
      nw = 0;
      while (e < e_en + 30) begin
         tick();
         n_total++; if (cp !== m_cp) $display("FAIL bnd_cp e=%0d got %b want %b", e, cp, m_cp); else n_pass++;
         n_total++; if (wrap !== m_wrap) $display("FAIL bnd_wrap e=%0d got %b want %b", e, wrap, m_wrap); else n_pass++;
         n_total++; if (cfg_ready !== (m_pend[0] == 0)) $display("FAIL bnd_ready e=%0d got %b want %b", e, cfg_ready, m_pend[0] == 0); else n_pass++;
         if (wrap[0] === 1'b1 && nw < 3) begin w[nw] = e - e_en; nw++; end
      end
      n_total++; if (nw != 3) $display("FAIL bnd_nwrap got %0d want 3", nw); else n_pass++;
      n_total++; if (w[0] != 10) $display("FAIL bnd_first got %0d want 10", w[0]); else n_pass++;
      n_total++; if (w[1] != 14 || w[2] != 18) $display("FAIL bnd_newper got %0d,%0d want 14,18", w[1], w[2]); else n_pass++;
      en[0] = 1'b0; tick();
   endtask

   task automatic test_small_div();
      logic exp_cp, exp_w;
      for (int d = 1; d >= 0; d--) begin
         for (int m = 0; m < 2; m++) begin
            en[1] = 1'b0; cfg_ch = 1'b1; cfg_div = 21'(d); cfg_mode = m[0]; cfg_valid = 1'b1;
            tick(); cfg_valid = 1'b0; tick(); tick();
            en[1] = 1'b1;
            for (int i = 0; i < 10; i++) begin
               tick();
               exp_w = (i >= 2) && (i % 2 == 0);
               exp_cp = (m == 1) ? (i % 2 == 1) : exp_w;
               n_total++; if (cp !== m_cp) $display("FAIL small_cp d=%0d m=%0d e=%0d got %b want %b", d, m, e, cp, m_cp); else n_pass++;
               n_total++; if (cp[1] !== exp_cp || wrap[1] !== exp_w)
                  $display("FAIL small_pattern d=%0d m=%0d i=%0d got %b%b want %b%b", d, m, i, cp[1], wrap[1], exp_cp, exp_w);
               else n_pass++;
            end
         end
      end
      en[1] = 1'b0; tick();
   endtask

   task automatic test_sync();
      en = 2'b00; tick();
      cfg_ch = 1'b0; cfg_div = 21'd5; cfg_mode = 1'($urandom_range(0, 1)); cfg_valid = 1'b1; tick();
      cfg_ch = 1'b1; cfg_mode = 1'($urandom_range(0, 1)); tick();
      cfg_valid = 1'b0; tick();
      en[0] = 1'b1;
      repeat ($urandom_range(1, 4)) tick();
      en[1] = 1'b1;
      repeat (7) begin
         tick();
         n_total++; if ({cp, wrap} !== {m_cp, m_wrap}) $display("FAIL sync_pre e=%0d got %b want %b", e, {cp, wrap}, {m_cp, m_wrap}); else n_pass++;
      end
      sync = 1'b1; tick(); sync = 1'b0;
      n_total++; if ({cp, wrap} !== 4'b0000) $display("FAIL sync_clear got %b want 0000", {cp, wrap}); else n_pass++;
      repeat (12) begin
         tick();
         n_total++; if ({cp, wrap} !== {m_cp, m_wrap}) $display("FAIL sync_post e=%0d got %b want %b", e, {cp, wrap}, {m_cp, m_wrap}); else n_pass++;
         n_total++; if (wrap[0] !== wrap[1]) $display("FAIL sync_align e=%0d got %b want equal bits", e, wrap); else n_pass++;
      end
      for (int i = 0; i < 10; i++) begin
         if (e + 1 - m_start[0] >= 5) break;
         tick();
      end
      sync = 1'b1; tick(); sync = 1'b0;
      n_total++; if (wrap !== 2'b00) $display("FAIL sync_on_wrap got %b want 00", wrap); else n_pass++;
      repeat (8) begin
         tick();
         n_total++; if ({cp, wrap} !== {m_cp, m_wrap}) $display("FAIL sync_after e=%0d got %b want %b", e, {cp, wrap}, {m_cp, m_wrap}); else n_pass++;
      end
      en = 2'b00; tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) en[0] = ~en[0];
         if ($urandom_range(0, 15) == 0) en[1] = ~en[1];
         sync = ($urandom_range(0, 31) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch = 1'($urandom_range(0, 1));
         cfg_div = 21'($urandom_range(0, 9));
         cfg_mode = 1'($urandom_range(0, 1));
         #1;
         n_total++; if (cfg_ready !== (m_pend[cfg_ch] == 0)) $display("FAIL rand_ready e=%0d got %b want %b", e, cfg_ready, m_pend[cfg_ch] == 0); else n_pass++;
         tick();
         n_total++; if (cp !== m_cp) $display("FAIL rand_cp e=%0d got %b want %b", e, cp, m_cp); else n_pass++;
         n_total++; if (wrap !== m_wrap) $display("FAIL rand_wrap e=%0d got %b want %b", e, wrap, m_wrap); else n_pass++;
      end
      sync = 1'b0; cfg_valid = 1'b0; en = 2'b00; tick(); tick();
   endtask

   task automatic test_reset_mid();
      int e_en, first, npulse;
      cfg_ch = 1'b0; cfg_div = 21'd10; cfg_mode = 1'b1; cfg_valid = 1'b1;
      tick(); cfg_valid = 1'b0; tick();
      en[0] = 1'b1;
      repeat (6) tick();
      cfg_div = 21'd3; cfg_mode = 1'b0; cfg_valid = 1'b1; tick(); cfg_valid = 1'b0; #1;
      n_total++; if (cfg_ready !== 1'b0) $display("FAIL rmid_pending got %b want 0", cfg_ready); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_total++; if ({cp, wrap} !== 4'b0000) $display("FAIL rmid_outputs got %b want 0000", {cp, wrap}); else n_pass++;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", cfg_ready); else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      e_en = e + 1; first = -1; npulse = 0;
      for (int i = 0; i < 8003; i++) begin
         tick();
         n_total++; if ({cp, wrap} !== {m_cp, m_wrap}) $display("FAIL rmid_model e=%0d got %b want %b", e, {cp, wrap}, {m_cp, m_wrap}); else n_pass++;
         if (cp[0] === 1'b1) begin
            if (npulse == 0) first = e;
            npulse++;
         end
      end
      n_total++; if (npulse != 1) $display("FAIL rmid_npulse got %0d want 1", npulse); else n_pass++;
      n_total++; if (first - e_en != 8000) $display("FAIL rmid_first got %0d want 8000", first - e_en); else n_pass++;
      en = 2'b00; tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_default_period();
      test_square7();
      test_cfg_boundary();
      test_small_div();
      test_sync();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
